cnt_seq_checker: RTL and testbench

- Receive-side consumer of the free-running 4-bit wrap-around counter stream (0,1,…,15,0,…).
- Samples the count on qualified cycles, acquires lock to the sequence, then flags breaks and counts them. Also counts wraps (15->0).
- Sits beside a counter as a self-check / monitor in lab designs; all outputs are registered.

---
 rtl/cnt_seq_checker_pkg.sv | 15 +
 rtl/cnt_seq_checker_sat_counter.sv | 37 +++
 rtl/cnt_seq_checker.sv | 125 ++++++++++++
 tb/tb_cnt_seq_checker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_checker_pkg.sv
// rtl/cnt_seq_checker_pkg.sv - shared FSM encoding and default parameters for the counter sequence checker
package cnt_seq_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int DEF_W      = 4;
  localparam int DEF_LOCK_N = 3;
  localparam int DEF_LOSS_N = 2;
  localparam int DEF_CW     = 8;

endpackage

// File: rtl/cnt_seq_checker_sat_counter.sv
// rtl/cnt_seq_checker_sat_counter.sv - CW-bit saturating incrementer with synchronous clear
module cnt_seq_checker_sat_counter
  import cnt_seq_checker_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // clear has priority over a coincident increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cnt_seq_checker.sv
// rtl/cnt_seq_checker.sv - locks onto a wrap-around count stream, flags breaks and counts errors and wraps
module cnt_seq_checker
  import cnt_seq_checker_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int LOSS_N = DEF_LOSS_N,
  parameter int CW     = DEF_CW
) (
  input  logic          CLK0,
  input  logic          RST,
  input  logic          en,
  input  logic [W-1:0]  cnt_in,
  input  logic          clr,
  output logic          locked,
  output logic          err_pulse,
  output logic          wrap_pulse,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] wrap_count
);

  localparam int GR_W = $clog2(LOCK_N + 1);
  localparam int MR_W = $clog2(LOSS_N + 1);

  state_e          state_q, state_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [GR_W-1:0] good_run_q, good_run_d, good_inc;
  logic [MR_W-1:0] miss_run_q, miss_run_d, miss_inc;
  logic            locked_q, locked_d;
  logic            err_pulse_q, err_pulse_d;
  logic            wrap_pulse_q, wrap_pulse_d;
  logic            match;

  assign match    = (cnt_in == exp_q);
  assign good_inc = good_run_q + GR_W'(1);
  assign miss_inc = miss_run_q + MR_W'(1);

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    good_run_d   = good_run_q;
    miss_run_d   = miss_run_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    if (en) begin
      // every sample resyncs the expectation to what was actually seen
      exp_d = cnt_in + W'(1);
      case (state_q)
        IDLE: begin
          good_run_d = '0;
          state_d    = ACQ;
        end
        ACQ: begin
          if (match) begin
            good_run_d = good_inc;
            if (good_inc == GR_W'(LOCK_N)) begin
              state_d    = LOCKED;
              miss_run_d = '0;
            end
          end else begin
            good_run_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_run_d   = '0;
            wrap_pulse_d = (cnt_in == '0);
          end else begin
            err_pulse_d = 1'b1;
            miss_run_d  = miss_inc;
            if (miss_inc == MR_W'(LOSS_N)) begin
              state_d    = ACQ;
              good_run_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK0 or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      good_run_q   <= '0;
      miss_run_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      good_run_q   <= good_run_d;
      miss_run_q   <= miss_run_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;

  cnt_seq_checker_sat_counter #(.CW(CW)) u_err_cnt (
    .clk   (CLK0),
    .rst_n (RST),
    .clr   (clr),
    .inc   (err_pulse_d),
    .count (err_count)
  );

  cnt_seq_checker_sat_counter #(.CW(CW)) u_wrap_cnt (
    .clk   (CLK0),
    .rst_n (RST),
    .clr   (clr),
    .inc   (wrap_pulse_d),
    .count (wrap_count)
  );

endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb/tb_cnt_seq_checker.sv - scoreboard bench for cnt_seq_checker (default and CW=2 instances)
module tb_cnt_seq_checker;

  logic       CLK0;
  logic       RST;
  logic       en;
  logic [3:0] cnt_in;
  logic       clr;

  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count, wrap_count;
  logic       locked_s, err_pulse_s, wrap_pulse_s;
  logic [1:0] err_count_s, wrap_count_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int en, cnt, clr;
    int l, e, w, ec, wc, ecs, wcs;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t mv;

  cnt_seq_checker dut (
    .CLK0(CLK0), .RST(RST), .en(en), .cnt_in(cnt_in), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  cnt_seq_checker #(.CW(2)) dut_s (
    .CLK0(CLK0), .RST(RST), .en(en), .cnt_in(cnt_in), .clr(clr),
    .locked(locked_s), .err_pulse(err_pulse_s), .wrap_pulse(wrap_pulse_s),
    .err_count(err_count_s), .wrap_count(wrap_count_s)
  );

  initial CLK0 = 1'b0;
  always #5 CLK0 = ~CLK0;

  function automatic void chk(string name, int idx, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s vec %0d actual %0d required %0d", name, idx, act, req);
    end
  endfunction

  task automatic add(int en_v, int cnt_v, int clr_v, int l, int e, int w,
                     int ec, int wc, int ecs, int wcs);
    vec_t v;
    v.idx = vecs.size() + 1;
    v.en = en_v; v.cnt = cnt_v; v.clr = clr_v;
    v.l = l; v.e = e; v.w = w; v.ec = ec; v.wc = wc; v.ecs = ecs; v.wcs = wcs;
    vecs.push_back(v);
  endtask

  // monitor: every edge that sampled a vector produces one expected record
  initial begin
    forever begin
      @(posedge CLK0);
      #2;
      if (exp_q.size() > 0) begin
        mv = exp_q.pop_front();
        chk("locked",       mv.idx, int'(locked),       mv.l);
        chk("err_pulse",    mv.idx, int'(err_pulse),    mv.e);
        chk("wrap_pulse",   mv.idx, int'(wrap_pulse),   mv.w);
        chk("err_count",    mv.idx, int'(err_count),    mv.ec);
        chk("wrap_count",   mv.idx, int'(wrap_count),   mv.wc);
        chk("locked_s",     mv.idx, int'(locked_s),     mv.l);
        chk("err_pulse_s",  mv.idx, int'(err_pulse_s),  mv.e);
        chk("err_count_s",  mv.idx, int'(err_count_s),  mv.ecs);
        chk("wrap_count_s", mv.idx, int'(wrap_count_s), mv.wcs);
      end
    end
  end

  initial begin
    RST = 1'b0; en = 1'b0; cnt_in = '0; clr = 1'b0;

    //  en cnt clr   L  E  W   EC WC ECs WCs
    add(1, 5, 0,    0, 0, 0,   0, 0, 0, 0);
    add(1, 6, 0,    0, 0, 0,   0, 0, 0, 0);
    add(1, 7, 0,    0, 0, 0,   0, 0, 0, 0);
    add(1, 8, 0,    1, 0, 0,   0, 0, 0, 0);
    add(1, 9, 0,    1, 0, 0,   0, 0, 0, 0);
    add(0, 3, 0,    1, 0, 0,   0, 0, 0, 0);
    add(0, 12, 0,   1, 0, 0,   0, 0, 0, 0);
    add(1, 10, 0,   1, 0, 0,   0, 0, 0, 0);
    add(1, 11, 0,   1, 0, 0,   0, 0, 0, 0);
    add(1, 12, 0,   1, 0, 0,   0, 0, 0, 0);
    add(1, 13, 0,   1, 0, 0,   0, 0, 0, 0);
    add(1, 14, 0,   1, 0, 0,   0, 0, 0, 0);
    add(1, 15, 0,   1, 0, 0,   0, 0, 0, 0);
    add(1, 0, 0,    1, 0, 1,   0, 1, 0, 1);
    add(1, 1, 0,    1, 0, 0,   0, 1, 0, 1);
    add(1, 2, 0,    1, 0, 0,   0, 1, 0, 1);
    add(1, 3, 0,    1, 0, 0,   0, 1, 0, 1);
    add(1, 4, 0,    1, 0, 0,   0, 1, 0, 1);
    add(1, 9, 0,    1, 1, 0,   1, 1, 1, 1);
    add(1, 10, 0,   1, 0, 0,   1, 1, 1, 1);
    add(1, 11, 0,   1, 0, 0,   1, 1, 1, 1);
    add(1, 6, 0,    1, 1, 0,   2, 1, 2, 1);
    add(1, 7, 0,    1, 0, 0,   2, 1, 2, 1);
    add(1, 0, 0,    1, 1, 0,   3, 1, 3, 1);
    add(1, 1, 0,    1, 0, 0,   3, 1, 3, 1);
    add(1, 2, 0,    1, 0, 0,   3, 1, 3, 1);
    add(1, 3, 0,    1, 0, 0,   3, 1, 3, 1);
    add(1, 4, 0,    1, 0, 0,   3, 1, 3, 1);
    add(1, 9, 0,    1, 1, 0,   4, 1, 3, 1);
    add(1, 2, 0,    0, 1, 0,   5, 1, 3, 1);
    add(1, 3, 0,    0, 0, 0,   5, 1, 3, 1);
    add(1, 4, 0,    0, 0, 0,   5, 1, 3, 1);
    add(1, 5, 0,    1, 0, 0,   5, 1, 3, 1);
    add(1, 9, 0,    1, 1, 0,   6, 1, 3, 1);
    add(1, 10, 0,   1, 0, 0,   6, 1, 3, 1);
    add(1, 0, 1,    1, 1, 0,   0, 0, 0, 0);
    add(1, 1, 0,    1, 0, 0,   0, 0, 0, 0);
    add(1, 7, 0,    1, 1, 0,   1, 0, 1, 0);
    add(1, 12, 0,   0, 1, 0,   2, 0, 2, 0);
    add(1, 13, 0,   0, 0, 0,   2, 0, 2, 0);
    add(1, 3, 0,    0, 0, 0,   2, 0, 2, 0);
    add(1, 4, 0,    0, 0, 0,   2, 0, 2, 0);
    add(1, 5, 0,    0, 0, 0,   2, 0, 2, 0);
    add(1, 6, 0,    1, 0, 0,   2, 0, 2, 0);

    // reset held with live random samples
    repeat (3) begin
      @(negedge CLK0);
      en = 1'b1;
      cnt_in = 4'($urandom_range(0, 15));
    end
    @(negedge CLK0);
    chk("rst_locked",     0, int'(locked),      0);
    chk("rst_err_pulse",  0, int'(err_pulse),   0);
    chk("rst_wrap_pulse", 0, int'(wrap_pulse),  0);
    chk("rst_err_count",  0, int'(err_count),   0);
    chk("rst_wrap_count", 0, int'(wrap_count),  0);
    chk("rst_locked_s",   0, int'(locked_s),    0);
    en = 1'b0;
    RST = 1'b1;
    @(posedge CLK0);
    #1;
    chk("post_rst_locked", 0, int'(locked), 0);

    foreach (vecs[i]) begin
      en     = vecs[i].en[0];
      cnt_in = 4'(vecs[i].cnt);
      clr    = vecs[i].clr[0];
      @(posedge CLK0);
      exp_q.push_back(vecs[i]);
      #1;
    end
    en = 1'b0;
    clr = 1'b0;

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK0);
    #3;
    if (exp_q.size() != 0) chk("drain_timeout", 0, exp_q.size(), 0);

    // asynchronous reset while locked, away from any clock edge
    @(negedge CLK0);
    chk("pre_rst_locked",    0, int'(locked),    1);
    chk("pre_rst_err_count", 0, int'(err_count), 2);
    RST = 1'b0;
    #1;
    chk("arst_locked",      0, int'(locked),      0);
    chk("arst_err_count",   0, int'(err_count),   0);
    chk("arst_wrap_count",  0, int'(wrap_count),  0);
    chk("arst_err_count_s", 0, int'(err_count_s), 0);
    chk("arst_locked_s",    0, int'(locked_s),    0);
    @(posedge CLK0);
    #1;
    chk("arst_hold_locked", 0, int'(locked), 0);
    RST = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
